// File: rtl/datapath_arbiter.sv
// datapath_arbiter: round-robin sharing of one primality-test datapath among NREQ requesters,
// with a one-cycle start pulse, watchdog abort and a one-cycle acknowledge per job.
module datapath_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 255,
    parameter int TW      = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [NREQ-1:0]   Req,
    input  logic [NREQ*W-1:0] N_in,
    output logic [NREQ-1:0]   Grant,
    output logic [NREQ-1:0]   Ack,
    output logic              Result,
    output logic              Err,
    output logic              Busy,
    output logic              Dp_start,
    output logic [W-1:0]      Dp_n,
    input  logic              Dp_done,
    input  logic              Dp_p
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN, RESP} state_t;

    state_t        state;
    logic [PW-1:0] ptr, owner, win;
    logic [TW-1:0] wd;
    logic          found;
    int            j;

    // first requester at or after ptr+1, wrapping
    always_comb begin
        win = ptr;
        found = 1'b0;
        j = 0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(ptr) + k) % NREQ;
            if (!found && Req[j]) begin
                win = PW'(j);
                found = 1'b1;
            end
        end
    end

    assign Busy     = state != IDLE;
    assign Dp_start = state == LAUNCH;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state  <= IDLE;
            Grant  <= '0;
            Ack    <= '0;
            Result <= 1'b0;
            Err    <= 1'b0;
            Dp_n   <= '0;
            wd     <= '0;
            ptr    <= PW'(NREQ - 1);
            owner  <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    Grant <= NREQ'(1) << win;
                    Dp_n  <= N_in[int'(win)*W +: W];
                    owner <= win;
                    state <= LAUNCH;
                end
                LAUNCH: begin
                    wd    <= '0;
                    state <= RUN;
                end
                RUN: if (Dp_done) begin
                    Result <= Dp_p;
                    Err    <= 1'b0;
                    Ack    <= Grant;
                    state  <= RESP;
                end else begin
                    wd <= wd + 1'b1;
                    // the watchdog reaches TIMEOUT on this edge
                    if (wd == TW'(TIMEOUT - 1)) begin
                        Result <= 1'b0;
                        Err    <= 1'b1;
                        Ack    <= Grant;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    ptr   <= owner;
                    Grant <= '0;
                    Ack   <= '0;
                    Err   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_datapath_arbiter.sv
// tb_datapath_arbiter: randomized scenarios against a round-robin/primality reference model.
module tb_datapath_arbiter;
    localparam int NREQ = 4, W = 8, TIMEOUT = 20, TW = 8;

    logic              Clk = 1'b0, Rst = 1'b1;
    logic [NREQ-1:0]   Req = '0;
    logic [NREQ*W-1:0] N_in = '0;
    logic              Dp_done = 1'b0, Dp_p = 1'b0;
    logic [NREQ-1:0]   Grant, Ack;
    logic              Result, Err, Busy, Dp_start;
    logic [W-1:0]      Dp_n;

    datapath_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .Clk(Clk), .Rst(Rst), .Req(Req), .N_in(N_in), .Grant(Grant), .Ack(Ack),
        .Result(Result), .Err(Err), .Busy(Busy), .Dp_start(Dp_start), .Dp_n(Dp_n),
        .Dp_done(Dp_done), .Dp_p(Dp_p)
    );

    always #5 Clk = ~Clk;

    int tests = 0, fails = 0, cyc = 0, dp_delay = 0, dp_left = 0, last = NREQ - 1;
    bit rand_dp = 1'b0;
    logic [NREQ-1:0] keep = '0;
    logic [NREQ-1:0] grant_q[$], ack_q[$];
    logic [W-1:0]    n_q[$];
    bit              res_q[$], err_q[$];
    int              start_cyc_q[$], ack_cyc_q[$], delay_q[$];

    function automatic bit is_prime(input logic [W-1:0] n);
        if (n < 2) return 1'b0;
        for (int d = 2; d * d <= int'(n); d++) if (int'(n) % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int rr_next(input logic [NREQ-1:0] m, input int from);
        for (int k = 1; k <= NREQ; k++) if (m[(from + k) % NREQ]) return (from + k) % NREQ;
        return -1;
    endfunction

    // one clock: observe at the falling edge, play the datapath and the requesters
    task automatic step();
        @(negedge Clk);
        cyc++;
        Dp_done = 1'b0;
        Dp_p = 1'($urandom);
        if (Dp_start) begin
            dp_left = rand_dp ? (($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 12))) : dp_delay;
            grant_q.push_back(Grant);
            n_q.push_back(Dp_n);
            start_cyc_q.push_back(cyc);
            delay_q.push_back(dp_left);
        end else if (dp_left > 0) begin
            dp_left--;
            if (dp_left == 0) begin
                Dp_done = 1'b1;
                Dp_p = is_prime(Dp_n);
            end
        end
        if (Ack != 0) begin
            ack_q.push_back(Ack);
            res_q.push_back(Result);
            err_q.push_back(Err);
            ack_cyc_q.push_back(cyc);
            Req = Req & ~(Ack & ~keep);
        end
    endtask

    task automatic run_until(input int n, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (ack_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        Req = '0;
        keep = '0;
        Rst = 1'b1;
        step();
        step();
        Rst = 1'b0;
        dp_left = 0;
        last = NREQ - 1;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        step();
        tests++;
        if ({Grant, Ack, Result, Err, Busy, Dp_start, Dp_n} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got %b want all zero", {Grant, Ack, Result, Err, Busy, Dp_start, Dp_n});
        end
        do_reset();
        for (int i = 0; i < 3; i++) step();
        tests++;
        if ({Busy, Grant, start_cyc_q.size() != 0} !== '0) begin
            fails++;
            $display("FAIL reset_idle busy=%b grant=%b starts=%0d want idle", Busy, Grant, start_cyc_q.size());
        end
    endtask

    task automatic test_single();
        bit ok;
        int b = ack_q.size(), s = start_cyc_q.size();
        rand_dp = 1'b0;
        dp_delay = 10;
        N_in = '0;
        N_in[W-1:0] = 8'd7;
        Req = 4'b0001;
        run_until(b + 1, 40, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL single_ack got none within 40 cycles want Ack");
        end else begin
            step();
            tests++;
            if (start_cyc_q.size() != s + 1) begin
                fails++;
                $display("FAIL single_start_count got %0d want 1", start_cyc_q.size() - s);
            end
            tests++;
            if (grant_q[s] !== 4'b0001 || n_q[s] !== 8'd7) begin
                fails++;
                $display("FAIL single_grant got grant=%b n=%0d want 0001/7", grant_q[s], n_q[s]);
            end
            tests++;
            if (ack_q[b] !== 4'b0001 || res_q[b] !== 1'b1 || err_q[b] !== 1'b0) begin
                fails++;
                $display("FAIL single_ack got ack=%b res=%b err=%b want 0001/1/0", ack_q[b], res_q[b], err_q[b]);
            end
            tests++;
            if (ack_cyc_q[b] - start_cyc_q[s] != 11) begin
                fails++;
                $display("FAIL single_latency got %0d want 11", ack_cyc_q[b] - start_cyc_q[s]);
            end
            tests++;
            if ({Busy, Grant, Ack} !== '0) begin
                fails++;
                $display("FAIL single_idle got busy=%b grant=%b ack=%b want 0", Busy, Grant, Ack);
            end
            last = 0;
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        int b, s, e;
        logic [NREQ-1:0] pend = 4'b1111;
        logic [W-1:0] ops[NREQ] = '{8'd2, 8'd4, 8'd13, 8'd15};
        do_reset();
        b = ack_q.size();
        s = start_cyc_q.size();
        rand_dp = 1'b0;
        dp_delay = int'($urandom_range(1, 8));
        for (int i = 0; i < NREQ; i++) N_in[i*W +: W] = ops[i];
        Req = pend;
        run_until(b + 4, 200, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL simul_acks got %0d want 4", ack_q.size() - b);
        end else begin
            for (int k = 0; k < 4; k++) begin
                e = rr_next(pend, last);
                pend[e] = 1'b0;
                last = e;
                tests++;
                if (ack_q[b+k] !== NREQ'(1) << e || n_q[s+k] !== ops[e]) begin
                    fails++;
                    $display("FAIL simul_order job%0d got ack=%b n=%0d want req%0d n=%0d", k, ack_q[b+k], n_q[s+k], e, ops[e]);
                end
                tests++;
                if (res_q[b+k] !== is_prime(ops[e]) || err_q[b+k] !== 1'b0) begin
                    fails++;
                    $display("FAIL simul_result job%0d got res=%b err=%b want %b/0", k, res_q[b+k], err_q[b+k], is_prime(ops[e]));
                end
            end
        end
    endtask

    task automatic test_fairness();
        bit ok;
        int b = ack_q.size(), e;
        for (int i = 0; i < NREQ; i++) N_in[i*W +: W] = W'($urandom);
        rand_dp = 1'b0;
        dp_delay = int'($urandom_range(1, 5));
        keep = 4'b0101;
        Req = 4'b0101;
        run_until(b + 6, 200, ok);
        keep = '0;
        Req = '0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL fair_acks got %0d want 6", ack_q.size() - b);
        end else begin
            for (int k = 0; k < 6; k++) begin
                e = rr_next(4'b0101, last);
                last = e;
                tests++;
                if (ack_q[b+k] !== NREQ'(1) << e || (k > 0 && ack_q[b+k] === ack_q[b+k-1])) begin
                    fails++;
                    $display("FAIL fair_order job%0d got ack=%b want req%0d", k, ack_q[b+k], e);
                end
            end
        end
        for (int i = 0; i < 3; i++) step();
        tests++;
        if (Busy !== 1'b0) begin
            fails++;
            $display("FAIL fair_idle got busy=%b want 0", Busy);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int b = ack_q.size(), s = start_cyc_q.size();
        rand_dp = 1'b0;
        dp_delay = 0;
        N_in[W +: W] = W'($urandom);
        Req = 4'b0010;
        run_until(b + 1, 60, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL timeout_ack got none within 60 cycles want Ack");
        end else begin
            tests++;
            if (ack_q[b] !== 4'b0010 || err_q[b] !== 1'b1 || res_q[b] !== 1'b0) begin
                fails++;
                $display("FAIL timeout_flags got ack=%b err=%b res=%b want 0010/1/0", ack_q[b], err_q[b], res_q[b]);
            end
            tests++;
            if (ack_cyc_q[b] - start_cyc_q[s] != TIMEOUT + 1) begin
                fails++;
                $display("FAIL timeout_latency got %0d want %0d", ack_cyc_q[b] - start_cyc_q[s], TIMEOUT + 1);
            end
            step();
            tests++;
            if ({Busy, Err, Ack} !== '0) begin
                fails++;
                $display("FAIL timeout_idle got busy=%b err=%b ack=%b want 0", Busy, Err, Ack);
            end
            last = 1;
        end
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int b = ack_q.size(), s = start_cyc_q.size(), e;
        rand_dp = 1'b0;
        dp_delay = 0;
        N_in[2*W +: W] = W'($urandom);
        Req = 4'b0100;
        for (int i = 0; i < 10 && start_cyc_q.size() == s; i++) step();
        for (int i = 0; i < 5; i++) step();
        Req = '0;
        Rst = 1'b1;
        #1;
        tests++;
        if ({Grant, Ack, Result, Err, Busy, Dp_start, Dp_n} !== '0) begin
            fails++;
            $display("FAIL midrst_async got %b want all zero", {Grant, Ack, Result, Err, Busy, Dp_start, Dp_n});
        end
        step();
        step();
        Rst = 1'b0;
        dp_left = 0;
        last = NREQ - 1;
        for (int i = 0; i < 3; i++) step();
        tests++;
        if (ack_q.size() != b || start_cyc_q.size() != s + 1) begin
            fails++;
            $display("FAIL midrst_no_ack got acks=%0d starts=%0d want 0/1", ack_q.size() - b, start_cyc_q.size() - s);
        end
        dp_delay = 3;
        Req = 4'b1001;
        run_until(b + 2, 60, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL midrst_resume got %0d acks want 2", ack_q.size() - b);
        end else begin
            for (int k = 0; k < 2; k++) begin
                e = rr_next(k == 0 ? 4'b1001 : 4'b1000, last);
                last = e;
                tests++;
                if (ack_q[b+k] !== NREQ'(1) << e) begin
                    fails++;
                    $display("FAIL midrst_order job%0d got ack=%b want req%0d", k, ack_q[b+k], e);
                end
            end
        end
    endtask

    task automatic test_drop_stray();
        bit ok;
        int b = ack_q.size(), s = start_cyc_q.size();
        logic [W-1:0] op = W'($urandom);
        rand_dp = 1'b0;
        dp_delay = 6;
        N_in[W +: W] = op;
        Req = 4'b0010;
        for (int i = 0; i < 10 && start_cyc_q.size() == s; i++) step();
        step();
        step();
        Req[1] = 1'b0;
        run_until(b + 1, 20, ok);
        tests++;
        if (!ok || ack_q[b] !== 4'b0010 || res_q[b] !== is_prime(op) || err_q[b] !== 1'b0) begin
            fails++;
            $display("FAIL drop_ack got ok=%b ack=%b res=%b want 0010/%b", ok, ok ? ack_q[b] : 4'b0, ok ? res_q[b] : 1'b0, is_prime(op));
        end
        last = 1;
        step();
        Dp_done = 1'b1;
        Dp_p = 1'b1;
        for (int i = 0; i < 4; i++) step();
        tests++;
        if ({Busy, Grant, Ack} !== '0 || ack_q.size() != b + 1 || start_cyc_q.size() != s + 1) begin
            fails++;
            $display("FAIL stray_done got busy=%b acks=%0d starts=%0d want idle/1/1", Busy, ack_q.size() - b, start_cyc_q.size() - s);
        end
    endtask

    task automatic test_random();
        bit ok;
        int b, s, e, n, lat;
        logic [NREQ-1:0] mask, pend;
        logic [W-1:0] ops[NREQ];
        rand_dp = 1'b1;
        for (int r = 0; r < 8; r++) begin
            b = ack_q.size();
            s = start_cyc_q.size();
            mask = NREQ'($urandom_range(1, 15));
            pend = mask;
            n = $countones(mask);
            for (int i = 0; i < NREQ; i++) begin
                ops[i] = W'($urandom);
                N_in[i*W +: W] = ops[i];
            end
            Req = mask;
            run_until(b + n, 400, ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL rand%0d_acks got %0d want %0d", r, ack_q.size() - b, n);
                break;
            end
            for (int k = 0; k < n; k++) begin
                e = rr_next(pend, last);
                pend[e] = 1'b0;
                last = e;
                lat = delay_q[s+k] == 0 ? TIMEOUT + 1 : delay_q[s+k] + 1;
                tests++;
                if (ack_q[b+k] !== NREQ'(1) << e || n_q[s+k] !== ops[e] || ack_cyc_q[b+k] - start_cyc_q[s+k] != lat) begin
                    fails++;
                    $display("FAIL rand%0d_job%0d got ack=%b n=%0d lat=%0d want req%0d n=%0d lat=%0d", r, k, ack_q[b+k], n_q[s+k], ack_cyc_q[b+k] - start_cyc_q[s+k], e, ops[e], lat);
                end
                tests++;
                if (err_q[b+k] !== (delay_q[s+k] == 0) || res_q[b+k] !== (delay_q[s+k] != 0 && is_prime(ops[e]))) begin
                    fails++;
                    $display("FAIL rand%0d_res%0d got res=%b err=%b want %b/%b", r, k, res_q[b+k], err_q[b+k], delay_q[s+k] != 0 && is_prime(ops[e]), delay_q[s+k] == 0);
                end
            end
        end
        rand_dp = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_timeout();
        test_reset_mid_run();
        test_drop_stray();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/datapath_arbiter.md
# datapath_arbiter

Round-robin scheduler that shares one primality-test datapath/FSM pair (8-bit operand N in, 1-bit prime flag P out) among up to NREQ requesters. It latches the winning requester's operand and issues a one-cycle start pulse. It then waits for the datapath's done, with a watchdog timeout, and returns the result with a one-cycle acknowledge. It sits between the switch/host-side request sources and the existing datapath/FSM pair, and replaces the direct Start/N wiring at the top level.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- W, 8, operand width
- TIMEOUT, 255, maximum RUN cycles before abort (1..2^TW-1)
- TW, 8, watchdog counter width

Ports:
- Clk  in  1  single clock, rising edge
- Rst  in  1  asynchronous, active-high reset
- Req  in  NREQ  per-requester request level; held until its Ack
- N_in  in  NREQ*W  operands; requester i uses bits [i*W +: W]; sampled only at grant
- Grant  out  NREQ  one-hot owner of the datapath; 0 when idle
- Ack  out  NREQ  one-hot, one-cycle completion pulse
- Result  out  1  prime flag for the acked job; valid only while Ack≠0
- Err  out  1  high with Ack when the job timed out
- Busy  out  1  high in every state except IDLE
- Dp_start  out  1  one-cycle start to the datapath FSM
- Dp_n  out  W  latched operand to the datapath, stable LAUNCH through RESP
- Dp_done  in  1  datapath completion level/pulse; sampled only in RUN
- Dp_p  in  1  datapath prime flag; sampled with Dp_done

## Operation
- States: IDLE, LAUNCH, RUN, RESP. All outputs are registered or decoded from state only (Moore).
- Reset: state=IDLE, Grant=0, Ack=0, Result=0, Err=0, Busy=0, Dp_start=0, Dp_n=0, watchdog=0, rr pointer=NREQ-1, so requester 0 has first priority.
- IDLE: if Req≠0, pick the first set bit searching from ptr+1 upward with wrap. Set Grant to the winner's one-hot, latch N_in slice into Dp_n, go to LAUNCH. If Req=0, stay.
- LAUNCH: Dp_start=1 for exactly this cycle. Clear the watchdog. Go to RUN.
- RUN on Dp_done=1: latch Result=Dp_p, Err=0, go to RESP.
- RUN, otherwise: increment the watchdog. When the watchdog reaches TIMEOUT, latch Result=0, Err=1, go to RESP.
- RESP: Ack=Grant for one cycle. Set ptr to the winner index. Then go to IDLE, clearing Grant, Ack and Err.
- Dp_done in IDLE/LAUNCH/RESP is ignored; no job is in flight there.
- If the granted requester drops Req mid-job, the job is not aborted. Ack is still issued.
- Req changes of other requesters during a job have no effect until the next IDLE.
- Asynchronous reset in any state abandons the job immediately. No Ack is produced and Dp_start is not reissued.

## Timing
- Edge e0 samples Req in IDLE. In cycle e0→e1, Grant, Dp_n and Dp_start=1 are valid.
- Edge e1 enters RUN, and Dp_start returns to 0.
- Dp_done sampled high at edge ek in RUN puts Ack/Result/Err valid in cycle ek→ek+1. Edge ek+1 returns to IDLE.
- Minimum Req→Ack latency: 3 cycles, with Dp_done high on the first RUN edge.
- Timeout: Ack with Err=1 appears exactly TIMEOUT+1 cycles after Dp_start.
- Turnaround: one IDLE cycle between jobs. Back-to-back grants are issued every (job length + 3) cycles.
- Requesters deassert Req on the edge that captures Ack. A Req still high at the next IDLE sample is a new request and is ranked by round-robin.
- Requester drops Req on the edge that captures Ack: the next IDLE sample sees it low, so no double service.

## Test plan
- Single job: after reset, Req=0001, N_in[0]=7, model asserts Dp_done with Dp_p=1 on RUN cycle 10. Required: Grant=0001, Dp_n=7, exactly one Dp_start pulse, Ack=0001 with Result=1 and Err=0, Busy low one cycle later.
- Simultaneous requests: Req=1111 with operands 2,4,13,15 held until each Ack. Required: service order 0,1,2,3 and Results 1,0,1,0.
- Fairness: Req[0] and Req[2] re-raised immediately after each Ack. Required: grants alternate 0,2,0,2; requester 0 is never granted twice in a row.
- Timeout: model never asserts Dp_done, TIMEOUT=20. Required: Ack with Err=1 and Result=0 exactly 21 cycles after Dp_start, then IDLE.
- Reset mid-RUN: Rst pulsed on RUN cycle 5. Required: all outputs 0 asynchronously, no Ack. The next request is served starting from requester 0 priority.
- Req drop and stray done: Req[1] dropped on RUN cycle 2 and Dp_done pulsed during IDLE. Required: Ack=0010 is still issued for the running job; the IDLE Dp_done causes no state change.
